// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and the LSB.
// Ports: clk_in/rst_in/rdy_in/clear, if_req/if_addr -> if_valid/if_inst,
//   ls_req/ls_store/ls_op/ls_addr/ls_data -> ls_valid/ls_val,
//   mem_din -> mem_dout/mem_a/mem_wr, io_buffer_full stalls UART stores.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  input  logic        ls_req,
  input  logic        ls_store,
  input  logic [5:0]  ls_op,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_data,
  output logic        ls_valid,
  output logic [31:0] ls_val,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] COOL  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  cnt;
  logic [2:0]  n_q;
  logic [5:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] d_q;
  logic [31:0] buf_q;

  logic [2:0]  ls_sz;
  logic [1:0]  bi;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;
  logic [31:0] ld_next_a;
  logic [31:0] st_addr;
  logic [7:0]  st_byte;
  logic        st_stall;
  logic        ld_more;

  always_comb begin
    ls_sz = 3'd4;
    unique case (1'b1)
      (ls_op == OP_LB || ls_op == OP_LBU || ls_op == OP_SB): ls_sz = 3'd1;
      (ls_op == OP_LH || ls_op == OP_LHU || ls_op == OP_SH): ls_sz = 3'd2;
      default: ls_sz = 3'd4;
    endcase
  end

  // Byte captured at edge with cnt=c belongs to lane c-1; the
  // final lane comes straight from mem_din at the done edge.
  assign bi = 2'(cnt - 3'd1);

  always_comb begin
    ld_word = buf_q;
    ld_word[{bi, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    ld_ext = ld_word;
    unique case (1'b1)
      (op_q == OP_LB):  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      (op_q == OP_LH):  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      (op_q == OP_LBU): ld_ext = {24'h0, ld_word[7:0]};
      (op_q == OP_LHU): ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  assign ld_next_a = a_q + {29'h0, cnt} + 32'd1;
  assign ld_more = ({1'b0, cnt} + 4'd1) < {1'b0, n_q};

  // In IDLE the first store byte is issued straight from the request.
  assign st_addr = (state == STORE) ? a_q + {29'h0, cnt} : ls_addr;
  assign st_byte = (state == STORE) ? d_q[{cnt[1:0], 3'b000} +: 8]
                                    : ls_data[7:0];
  assign st_stall = (st_addr[17:16] == 2'b11) && io_buffer_full;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      n_q      <= 3'd0;
      op_q     <= 6'd0;
      a_q      <= 32'h0;
      d_q      <= 32'h0;
      buf_q    <= 32'h0;
      if_valid <= 1'b0;
      if_inst  <= 32'h0;
      ls_valid <= 1'b0;
      ls_val   <= 32'h0;
      mem_a    <= 32'h0;
      mem_dout <= 8'h0;
      mem_wr   <= 1'b0;
    end else if (!rdy_in) begin
      mem_wr <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (!clear) begin
            if (ls_req) begin
              a_q   <= ls_addr;
              d_q   <= ls_data;
              op_q  <= ls_op;
              n_q   <= ls_sz;
              buf_q <= 32'h0;
              mem_a <= ls_addr;
              cnt   <= 3'd0;
              if (ls_store) begin
                state <= STORE;
                if (!st_stall) begin
                  mem_wr   <= 1'b1;
                  mem_dout <= st_byte;
                  cnt      <= 3'd1;
                end
              end else begin
                state <= LOAD;
              end
            end else if (if_req) begin
              a_q   <= if_addr;
              n_q   <= 3'd4;
              buf_q <= 32'h0;
              mem_a <= if_addr;
              cnt   <= 3'd0;
              state <= FETCH;
            end
          end
        end
        FETCH, LOAD: begin
          if (clear) begin
            state <= IDLE;
          end else if (cnt == n_q) begin
            state <= COOL;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_inst  <= ld_word;
            end else begin
              ls_valid <= 1'b1;
              ls_val   <= ld_ext;
            end
          end else begin
            if (cnt != 3'd0) buf_q <= ld_word;
            if (ld_more) mem_a <= ld_next_a;
            cnt <= cnt + 3'd1;
          end
        end
        STORE: begin
          // A committed store ignores clear and always completes.
          if (cnt == n_q) begin
            state    <= COOL;
            ls_valid <= 1'b1;
          end else if (!st_stall) begin
            mem_wr   <= 1'b1;
            mem_a    <= st_addr;
            mem_dout <= st_byte;
            cnt      <= cnt + 3'd1;
          end
        end
        COOL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a time-stamped scoreboard
// checked by a monitor on the falling edge.
module tb_mem_arbiter;

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam int K_WR = 0;
  localparam int K_IF = 1;
  localparam int K_LS = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        ls_req;
  logic        ls_store;
  logic [5:0]  ls_op;
  logic [31:0] ls_addr;
  logic [31:0] ls_data;
  logic        ls_valid;
  logic [31:0] ls_val;
  logic [7:0]  mem_din = 8'h0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr),
    .if_valid(if_valid), .if_inst(if_inst),
    .ls_req(ls_req), .ls_store(ls_store), .ls_op(ls_op),
    .ls_addr(ls_addr), .ls_data(ls_data),
    .ls_valid(ls_valid), .ls_val(ls_val),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    bit          cd;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic [7:0] ram [logic [31:0]];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Byte RAM with one-cycle read latency.
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic got(input int kind, input logic [31:0] a,
                     input logic [31:0] d);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected kind=%0d cyc=%0d addr=%h data=%h want none",
               kind, cyc, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind == kind && e.cyc == cyc &&
          (e.kind != K_WR || e.addr == a) && (!e.cd || e.data == d))
        passes++;
      else
        $display("FAIL event got kind=%0d cyc=%0d addr=%h data=%h want kind=%0d cyc=%0d addr=%h data=%h",
                 kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      if (mem_wr)   got(K_WR, mem_a, {24'h0, mem_dout});
      if (if_valid) got(K_IF, 32'h0, if_inst);
      if (ls_valid) got(K_LS, 32'h0, ls_val);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got %h want %h", nm, act, exp);
  endtask

  task automatic push(input int kind, input logic [31:0] a,
                      input logic [31:0] d, input int c, input bit cd);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.cyc = c; e.cd = cd;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  function automatic int nsz(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
    push(K_IF, 0, exp, cyc + 1 + 5, 1);
    if_req = 1'b1; if_addr = a;
    tick(1); if_req = 1'b0;
    tick(6);
  endtask

  task automatic load(input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] exp);
    int n;
    n = nsz(op);
    push(K_LS, 0, exp, cyc + 1 + n + 1, 1);
    ls_req = 1'b1; ls_store = 1'b0; ls_op = op; ls_addr = a;
    tick(1); ls_req = 1'b0;
    tick(n + 2);
  endtask

  task automatic push_store(input int e0, input int n, input logic [31:0] a,
                            input logic [31:0] d, input int done);
    for (int k = 0; k < n; k++)
      push(K_WR, a + k, {24'h0, d[8*k +: 8]}, e0 + k, 1);
    push(K_LS, 0, 0, done, 0);
  endtask

  task automatic store(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d);
    int n;
    int e0;
    n = nsz(op);
    e0 = cyc + 1;
    push_store(e0, n, a, d, e0 + n);
    ls_req = 1'b1; ls_store = 1'b1; ls_op = op; ls_addr = a; ls_data = d;
    tick(1); ls_req = 1'b0;
    tick(n + 1);
  endtask

  initial begin
    int e0;
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    if_req = 1'b0; if_addr = 0;
    ls_req = 1'b0; ls_store = 1'b0; ls_op = 0; ls_addr = 0; ls_data = 0;
    io_buffer_full = 1'b0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
    ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2003] = 8'h80;
    tick(2);
    chk("rst_if_valid", {31'h0, if_valid}, 0);
    chk("rst_ls_valid", {31'h0, ls_valid}, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_ls_val", ls_val, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 0);
    rst_in = 1'b1;

    fetch(32'h1000, 32'h0000_0513);
    load(OP_LB, 32'h2003, 32'hFFFF_FF80);
    load(OP_LBU, 32'h2003, 32'h0000_0080);
    store(OP_SW, 32'h100, 32'hDEAD_BEEF);
    load(OP_LW, 32'h100, 32'hDEAD_BEEF);
    load(OP_LH, 32'h100, 32'hFFFF_BEEF);
    load(OP_LHU, 32'h102, 32'h0000_DEAD);
    store(OP_SH, 32'h200, 32'hAAAA_7F12);
    load(OP_LH, 32'h200, 32'h0000_7F12);
    load(OP_LB, 32'h201, 32'h0000_007F);
    store(OP_SW, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    load(OP_LW, 32'hFFFF_FFFE, 32'hCAFE_F00D);

    // Simultaneous requests: LSB first, fetch accepted two edges after done.
    e0 = cyc + 1;
    push(K_LS, 0, 32'hFFFF_FF80, e0 + 2, 1);
    push(K_IF, 0, 32'h0000_0513, e0 + 4 + 5, 1);
    ls_req = 1'b1; ls_store = 1'b0; ls_op = OP_LB; ls_addr = 32'h2003;
    if_req = 1'b1; if_addr = 32'h1000;
    tick(1); ls_req = 1'b0;
    tick(4); if_req = 1'b0;
    tick(6);

    // UART store held off by a full buffer for three edges.
    e0 = cyc + 1;
    push_store(e0 + 3, 1, 32'h30000, 32'h41, e0 + 4);
    ls_req = 1'b1; ls_store = 1'b1; ls_op = OP_SB;
    ls_addr = 32'h30000; ls_data = 32'h41; io_buffer_full = 1'b1;
    tick(1); ls_req = 1'b0;
    tick(2); io_buffer_full = 1'b0;
    tick(3);
    load(OP_LBU, 32'h30000, 32'h0000_0041);

    // rdy_in low for one edge mid-store.
    e0 = cyc + 1;
    push(K_WR, 32'h300, 32'h04, e0, 1);
    push(K_WR, 32'h301, 32'h03, e0 + 1, 1);
    push(K_WR, 32'h302, 32'h02, e0 + 3, 1);
    push(K_WR, 32'h303, 32'h01, e0 + 4, 1);
    push(K_LS, 0, 0, e0 + 5, 0);
    ls_req = 1'b1; ls_store = 1'b1; ls_op = OP_SW;
    ls_addr = 32'h300; ls_data = 32'h0102_0304;
    tick(1); ls_req = 1'b0;
    tick(1); rdy_in = 1'b0;
    tick(1); rdy_in = 1'b1;
    tick(4);

    // clear at E2 of a load: no result.
    ls_req = 1'b1; ls_store = 1'b0; ls_op = OP_LW; ls_addr = 32'h1000;
    tick(1); ls_req = 1'b0;
    tick(1); clear = 1'b1;
    tick(1); clear = 1'b0;
    tick(4);

    // clear at E2 of a store: completes anyway.
    e0 = cyc + 1;
    push_store(e0, 4, 32'h400, 32'h1122_3344, e0 + 4);
    ls_req = 1'b1; ls_store = 1'b1; ls_op = OP_SW;
    ls_addr = 32'h400; ls_data = 32'h1122_3344;
    tick(1); ls_req = 1'b0;
    tick(1); clear = 1'b1;
    tick(1); clear = 1'b0;
    tick(3);
    load(OP_LW, 32'h400, 32'h1122_3344);

    // clear in IDLE blocks acceptance for that edge.
    ls_req = 1'b1; ls_store = 1'b0; ls_op = OP_LBU; ls_addr = 32'h2003;
    clear = 1'b1;
    tick(1); clear = 1'b0;
    push(K_LS, 0, 32'h0000_0080, cyc + 1 + 2, 1);
    tick(1); ls_req = 1'b0;
    tick(3);

    // Reset mid-load abandons it; fetch accepted at first edge after release.
    ls_req = 1'b1; ls_store = 1'b0; ls_op = OP_LW; ls_addr = 32'h1000;
    tick(1); ls_req = 1'b0;
    tick(1); rst_in = 1'b0;
    #1;
    chk("midrst_mem_a", mem_a, 0);
    chk("midrst_flags", {29'h0, if_valid, ls_valid, mem_wr}, 0);
    tick(2);
    if_req = 1'b1; if_addr = 32'h1000; rst_in = 1'b1;
    push(K_IF, 0, 32'h0000_0513, cyc + 1 + 5, 1);
    tick(1); if_req = 1'b0;
    tick(8);

    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL pending got %0d events left want 0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk_in  input  1  single clock, all state on rising edge.
REQ-002 rst_in  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 rdy_in  input  1  global enable; 0 freezes all state.
REQ-004 clear  input  1  pipeline flush from RoB.
REQ-005 if_req, if_addr[31:0]  input  1/32  instruction-fetch request, 4-byte word.
REQ-006 if_valid, if_inst[31:0]  output  1/32  fetch done pulse, little-endian word.
REQ-007 ls_req, ls_store, ls_op[5:0], ls_addr[31:0], ls_data[31:0]  input  LSB request (store=1 write; op = const.v Lb..Lhu/Sb..Sw).
REQ-008 ls_valid, ls_val[31:0]  output  1/32  LSB done pulse, load data (mem_valid/mem_val of LSB).
REQ-009 mem_din[7:0] input; mem_dout[7:0], mem_a[31:0], mem_wr output  byte RAM port, mem_wr=1 write.
REQ-010 io_buffer_full  input  1  UART buffer full.

Function
REQ-011 States: IDLE, FETCH, LOAD, STORE, COOL; byte counter cnt[2:0], size n in {1,2,4}.
REQ-012 Size: Lb/Lbu/Sb n=1; Lh/Lhu/Sh n=2; Lw/Sw/fetch n=4.
REQ-013 IDLE accept: ls_req has priority over if_req; if_req taken only when ls_req=0.
REQ-014 Accept edge E0: latch addr/op/data, cnt=0, drive mem_a=addr, move to LOAD/STORE/FETCH.
REQ-015 Read: address A+k driven in cycle after E_k; mem_din for A+k valid cycle after E_(k+1), captured at E_(k+2) into bits [8k+7:8k].
REQ-016 Read done: last byte captured at E_(n+1) straight from mem_din; ls_valid/if_valid =1 in cycle after E_(n+1); lw/fetch done after E5, lb after E2.
REQ-017 Load extension: Lb/Lh sign-extend from bit 7/15; Lbu/Lhu zero-extend; Lw unchanged.
REQ-018 Write: cycle after E_k: mem_wr=1, mem_a=A+k, mem_dout=ls_data[8k+7:8k]; done pulse in cycle after E_n (sw after E4, sb after E1).
REQ-019 IO stall: address with addr[17:16]=2'b11 and io_buffer_full=1 -> no byte issued that cycle (mem_wr=0), cnt holds, retry next cycle.
REQ-020 Done pulses exactly one cycle; state goes COOL for that cycle; no request accepted in COOL; IDLE next cycle.
REQ-021 mem_wr=0 in every cycle not issuing a store byte; mem_a/mem_dout hold last value otherwise.
REQ-022 clear during FETCH/LOAD: abort at that edge, no done pulse, -> IDLE next cycle, partial data discarded.
REQ-023 clear during STORE: remaining bytes still written to completion; done pulse still asserted (store is committed).
REQ-024 clear in IDLE: no request accepted that edge.
REQ-025 rdy_in=0: state, cnt, outputs frozen except mem_wr forced 0; resumes at same byte when rdy_in=1.
REQ-026 Address arithmetic A+k is 32-bit, wraps modulo 2^32.
REQ-027 if_valid and ls_valid never both 1 in same cycle.

Reset
REQ-028 rst_in=0 immediately: state=IDLE, cnt=0, if_valid=0, ls_valid=0, if_inst=0, ls_val=0, mem_a=0, mem_dout=0, mem_wr=0.
REQ-029 Reset mid-transaction abandons it; no done pulse after release; first accept at first edge with rst_in=1.

Verification
REQ-030 Fetch 0x1000, RAM bytes 13 05 00 00 -> if_valid one cycle after E5, if_inst=0x00000513, mem_wr=0 throughout.
REQ-031 Lb at 0x2003 byte 0x80 -> ls_val=0xFFFFFF80 after E2; same as Lbu -> 0x00000080.
REQ-032 Sw 0xDEADBEEF to 0x100 -> writes EF,BE,AD,DE to 0x100..0x103 in 4 consecutive cycles, ls_valid after E4.
REQ-033 if_req and ls_req same cycle -> LSB served first; fetch starts cycle after ls_valid's COOL cycle.
REQ-034 Sb 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write, ls_valid next cycle.
REQ-035 clear at E2 of lw -> no ls_valid, IDLE; clear at E2 of sw -> all 4 bytes written, ls_valid after E4.
